// File: rtl/pdm_cic_filter_pkg.sv
// Shared widths, default ratios and the output quantizer for the PDM decimation filter.
package pdm_cic_filter_pkg;

  localparam int unsigned C1_IBW = 2;
  localparam int unsigned C1_OBW = 2;
  localparam int unsigned I1_BW  = 9;
  localparam int unsigned C2_IBW = 8;
  localparam int unsigned C2_OBW = 9;
  localparam int unsigned I2_BW  = 17;
  localparam int unsigned OUT_BW = 8;

  localparam int unsigned DECIM_DEF       = 250;
  localparam int unsigned DC_OFFSET_DEF   = 125;
  localparam int unsigned QUANT_SHIFT_DEF = 5;

  localparam logic signed [I2_BW-1:0] Q_MAX = I2_BW'(127);
  localparam logic signed [I2_BW-1:0] Q_MIN = I2_BW'(-128);

  // Floor shift, then saturate into the signed output range.
  function automatic logic signed [OUT_BW-1:0] quantize(input logic signed [I2_BW-1:0] v,
                                                        input int unsigned sh);
    logic signed [I2_BW-1:0] s;
    s = v >>> sh;
    if (s > Q_MAX)      return Q_MAX[OUT_BW-1:0];
    else if (s < Q_MIN) return Q_MIN[OUT_BW-1:0];
    else                return s[OUT_BW-1:0];
  endfunction

endpackage

// File: rtl/pdm_cic_filter_comb.sv
// Comb section: y[n] = x[n] - x[n-DEPTH] over a zero-initialised delay line.
module pdm_cic_filter_comb #(
  parameter int unsigned I_BW  = 2,
  parameter int unsigned O_BW  = 2,
  parameter int unsigned DEPTH = 250
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic signed [I_BW-1:0] data_i,
  output logic                   valid_o,
  output logic signed [O_BW-1:0] data_o
);

  logic signed [I_BW-1:0] dly [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) dly[i] <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (!en_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) dly[i] <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        dly[0] <= data_i;
        for (int unsigned i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
        data_o <= O_BW'(data_i) - O_BW'(dly[DEPTH-1]);
      end
    end
  end

endmodule

// File: rtl/pdm_cic_filter_decim.sv
// Decimator: forwards every DECIM-th valid sample and holds it between pulses.
module pdm_cic_filter_decim #(
  parameter int unsigned DECIM = 250,
  parameter int unsigned W     = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic                valid_i,
  input  logic signed [W-1:0] data_i,
  output logic                valid_o,
  output logic signed [W-1:0] data_o
);

  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (!en_i) begin
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_i) begin
        if (cnt == CW'(DECIM - 1)) begin
          cnt     <= '0;
          data_o  <= data_i;
          valid_o <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pdm_cic_filter_integ.sv
// Integrator section: wrapping signed accumulator advanced on each input strobe.
module pdm_cic_filter_integ #(
  parameter int unsigned I_BW = 2,
  parameter int unsigned O_BW = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic signed [I_BW-1:0] data_i,
  output logic                   valid_o,
  output logic signed [O_BW-1:0] data_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (!en_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) data_o <= data_o + O_BW'(data_i);
    end
  end

endmodule

// File: rtl/pdm_cic_filter.sv
// PDM to 8-bit PCM: comb/integrator, DC cancel, comb/integrator, register, quantize, decimate.
module pdm_cic_filter
  import pdm_cic_filter_pkg::*;
#(
  parameter int unsigned DECIM       = DECIM_DEF,
  parameter int unsigned DC_OFFSET   = DC_OFFSET_DEF,
  parameter int unsigned QUANT_SHIFT = QUANT_SHIFT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic                     data_i,
  input  logic                     valid_i,
  output logic signed [OUT_BW-1:0] data_o,
  output logic                     valid_o
);

  logic signed [C1_IBW-1:0] c1_in;
  logic signed [C1_OBW-1:0] c1_y;
  logic signed [I1_BW-1:0]  i1_y;
  logic signed [C2_IBW-1:0] dc;
  logic signed [C2_OBW-1:0] c2_y;
  logic signed [I2_BW-1:0]  i2_y;
  logic signed [I2_BW-1:0]  or_y;
  logic signed [OUT_BW-1:0] q;
  logic c1_vld, i1_vld, c2_vld, i2_vld, or_vld;

  assign c1_in = {1'b0, data_i};

  pdm_cic_filter_comb #(.I_BW(C1_IBW), .O_BW(C1_OBW), .DEPTH(DECIM)) u_comb1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .valid_i(valid_i), .data_i(c1_in), .valid_o(c1_vld), .data_o(c1_y));

  pdm_cic_filter_integ #(.I_BW(C1_OBW), .O_BW(I1_BW)) u_integ1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .valid_i(c1_vld), .data_i(c1_y), .valid_o(i1_vld), .data_o(i1_y));

  // Ones-count minus the mid-scale count; fits 8b signed since the count is 0..250.
  assign dc = C2_IBW'(i1_y - $signed(I1_BW'(DC_OFFSET)));

  pdm_cic_filter_comb #(.I_BW(C2_IBW), .O_BW(C2_OBW), .DEPTH(DECIM)) u_comb2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .valid_i(i1_vld), .data_i(dc), .valid_o(c2_vld), .data_o(c2_y));

  pdm_cic_filter_integ #(.I_BW(C2_OBW), .O_BW(I2_BW)) u_integ2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .valid_i(c2_vld), .data_i(c2_y), .valid_o(i2_vld), .data_o(i2_y));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      or_y   <= '0;
      or_vld <= 1'b0;
    end else if (!en_i) begin
      or_y   <= '0;
      or_vld <= 1'b0;
    end else begin
      or_vld <= i2_vld;
      if (i2_vld) or_y <= i2_y;
    end
  end

  assign q = quantize(or_y, QUANT_SHIFT);

  pdm_cic_filter_decim #(.DECIM(DECIM), .W(OUT_BW)) u_decim (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .valid_i(or_vld), .data_i(q), .valid_o(valid_o), .data_o(data_o));

endmodule

// File: tb/tb_pdm_cic_filter.sv
// Directed bench for pdm_cic_filter with a moving-sum reference model and output scoreboard.
module tb_pdm_cic_filter;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  logic en_i    = 1'b1;
  logic data_i  = 1'b0;
  logic valid_i = 1'b0;
  logic signed [7:0] data_o;
  logic valid_o;

  int compared   = 0;
  int mismatched = 0;
  longint cyc = 0;

  int     exp_val_q[$];
  longint exp_cyc_q[$];
  int     bits[$];

  pdm_cic_filter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i),
    .valid_i(valid_i), .data_o(data_o), .valid_o(valid_o));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: sum over the last 250 samples of (ones in the 250-bit window ending there) - 125.
  function automatic void model_bit(input int b, input longint c);
    int n;
    int ones;
    int sum;
    int s;
    bits.push_back(b);
    n = bits.size();
    if (n % 250 == 0) begin
      sum = 0;
      for (int k = n - 249; k <= n; k++) begin
        ones = 0;
        for (int j = (k - 249 < 1) ? 1 : k - 249; j <= k; j++) ones += bits[j-1];
        sum += ones - 125;
      end
      s = sum >>> 5;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      exp_val_q.push_back(s);
      exp_cyc_q.push_back(c + 6);
    end
  endfunction

  always @(negedge clk_i) begin
    if (valid_o) begin
      chk("valid_o_expected", longint'(exp_val_q.size() > 0), 1);
      if (exp_val_q.size() > 0) begin
        chk("data_o", data_o, exp_val_q.pop_front());
        chk("valid_o_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  task automatic send_bit(input int b, input int period);
    @(negedge clk_i);
    data_i  = b[0];
    valid_i = 1'b1;
    model_bit(b, cyc);
    if (period > 1) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (period - 2) @(negedge clk_i);
    end
  endtask

  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_val_q.size() != 0; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    chk(tag, exp_val_q.size(), 0);
  endtask

  task automatic clear_en(input string tag);
    @(negedge clk_i);
    en_i = 1'b0;
    bits.delete();
    repeat (2) @(negedge clk_i);
    chk({tag, "_data_o"}, data_o, 0);
    chk({tag, "_valid_o"}, valid_o, 0);
    en_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_data_o", data_o, 0);
    chk("reset_valid_o", valid_o, 0);
    rst_n_i = 1'b1;

    // All ones, one bit per cycle: 3 then 127, 250 cycles apart.
    for (int i = 0; i < 500; i++) send_bit(1, 1);
    idle();
    drain("drain_ones");

    // Asynchronous reset mid-cycle at bit 130 of a fresh frame.
    for (int i = 0; i < 130; i++) send_bit(1, 1);
    idle();
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    bits.delete();
    #1;
    chk("async_rst_data_o", data_o, 0);
    chk("async_rst_valid_o", valid_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 250; i++) send_bit(1, 1);
    idle();
    drain("drain_after_rst");

    // All zeros at one bit every 3 cycles: -128 twice, 750 cycles apart.
    clear_en("clr_zeros");
    for (int i = 0; i < 500; i++) send_bit(0, 3);
    idle();
    drain("drain_zeros");

    // Alternating 0/1: steady state gives 0 for outputs 3 and 4.
    clear_en("clr_alt");
    for (int i = 0; i < 1000; i++) send_bit(i % 2, 1);
    idle();
    drain("drain_alt");

    // Disable at bit 400, then 250 random bits yield exactly one output.
    clear_en("clr_en_test");
    for (int i = 0; i < 400; i++) send_bit(1, 2);
    idle();
    clear_en("en_drop");
    for (int i = 0; i < 250; i++) send_bit(int'($urandom_range(0, 1)), 1);
    idle();
    drain("drain_random");

    chk("final_queue_empty", exp_val_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
